mips_fetch_stage: RTL and testbench

- Instruction-fetch front end of the 5-stage MIPSpipeline.
- Owns the program counter and drives a single-outstanding-request instruction-memory handshake.
- Produces the IF/ID pipeline register consumed by the decode stage.
- Honours hazard-unit stalls and branch/jump redirects from later stages.
- Exports the fetch PC as current_pc for top-level observation.

---
 rtl/mips_fetch_stage.sv | 127 ++++++++++++
 tb/tb_mips_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: IF stage owning the PC, a single-outstanding imem handshake and the IF/ID register.
// Ports:
//   clk, reset (async, active-low)
//   stall_i, redirect_i, redirect_pc_i    : hazard stall and branch/jump redirect from later stages
//   imem_req_o, imem_addr_o               : fetch request and word address
//   imem_ready_i, imem_rdata_i            : transaction completes when req and ready are both high
//   ifid_valid_o/instr_o/pc_o/pc4_o       : IF/ID pipeline register
//   current_pc_o                          : fetch PC register
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] current_pc_o
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, drain_addr_q, drain_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d, ifid_pc4_q, ifid_pc4_d;
    logic [31:0] target, pc_next;
    assign target       = redirect_pc_i & 32'hFFFF_FFFC;
    assign pc_next      = pc_q + PC_INC;
    // req drops combinationally with reset so an in-flight request is abandoned immediately
    assign imem_req_o   = reset && state_q != HOLD;
    // while draining, the request already on the bus must keep its address until accepted
    assign imem_addr_o  = state_q == DRAIN ? drain_addr_q : pc_q;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign current_pc_o = pc_q;
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    pc_d         = target;
                    ifid_valid_d = 1'b0;
                    if (!imem_ready_i) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ready_i) begin
                    pc_d = pc_next;
                    if (stall_i) begin
                        // response arrived while decode is frozen: park it in the skid
                        skid_instr_d = imem_rdata_i;
                        skid_pc_d    = pc_q;
                        state_d      = HOLD;
                    end else begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_rdata_i;
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_next;
                    end
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (redirect_i) pc_d = target;
                if (imem_ready_i) state_d = FETCH;
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d         = target;
                    ifid_valid_d = 1'b0;
                    state_d      = FETCH;
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_instr_d = skid_instr_q;
                    ifid_pc_d    = skid_pc_q;
                    ifid_pc4_d   = skid_pc_q + PC_INC;
                    state_d      = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC & 32'hFFFF_FFFC;
            drain_addr_q <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end
endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: directed and randomized checks of mips_fetch_stage against a queue-based fetch model.
module tb_mips_fetch_stage;
    logic        clk = 1'b0, reset = 1'b0, stall_i = 1'b0, redirect_i = 1'b0, imem_ready_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o, ifid_valid_o, w_req, w_valid;
    logic [31:0] imem_addr_o, imem_rdata_i, ifid_instr_o, ifid_pc_o, ifid_pc4_o, current_pc_o;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4, w_cur;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
    endfunction

    assign imem_rdata_i = mem(imem_addr_o);
    assign w_rdata      = mem(w_addr);

    mips_fetch_stage dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i), .ifid_valid_o(ifid_valid_o),
        .ifid_instr_o(ifid_instr_o), .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o),
        .current_pc_o(current_pc_o)
    );

    mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ready_i(imem_ready_i), .imem_rdata_i(w_rdata), .ifid_valid_o(w_valid),
        .ifid_instr_o(w_instr), .ifid_pc_o(w_pc), .ifid_pc4_o(w_pc4), .current_pc_o(w_cur)
    );

    // Reference model: the skid and the undrained request are each a queue of fetch addresses;
    // an instruction's word is always mem(its address).
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_v;
    logic [31:0] skid_q[$], drain_q[$];

    task automatic model_reset();
        m_pc = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
        skid_q.delete(); drain_q.delete();
    endtask

    task automatic deliver(input logic [31:0] p);
        m_v = 1; m_instr = mem(p); m_ipc = p; m_ipc4 = p + 32'd4;
    endtask

    task automatic model_step(input logic rdy, input logic st, input logic rd, input logic [31:0] tgt);
        logic [31:0] t;
        t = tgt & 32'hFFFF_FFFC;
        if (skid_q.size() != 0) begin
            if (rd) begin skid_q.delete(); m_pc = t; m_v = 0; end
            else if (!st) deliver(skid_q.pop_front());
        end else if (drain_q.size() != 0) begin
            if (rdy) drain_q.delete();
            if (rd) m_pc = t;
        end else if (rd) begin
            if (!rdy) drain_q.push_back(m_pc);
            m_pc = t; m_v = 0;
        end else if (rdy) begin
            if (st) skid_q.push_back(m_pc); else deliver(m_pc);
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_v = 0;
        end
    endtask

    function automatic logic [193:0] model_out();
        return {skid_q.size() == 0, drain_q.size() != 0 ? drain_q[0] : m_pc,
                m_v, m_instr, m_ipc, m_ipc4, m_pc};
    endfunction

    task automatic cyc(input logic rdy, input logic st, input logic rd, input logic [31:0] tgt);
        imem_ready_i = rdy; stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
        @(posedge clk);
        model_step(rdy, st, rd, tgt);
        @(negedge clk);
    endtask

    task automatic test_reset();
        imem_ready_i = 1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({imem_req_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o, current_pc_o} !== '0) begin
            n_err++;
            $display("FAIL reset_main: got req=%b v=%b instr=%h pc=%h pc4=%h cur=%h, want all zero",
                     imem_req_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o, current_pc_o);
        end
        n_vec++;
        if ({w_req, w_valid, w_cur} !== {2'b00, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL reset_wrap: got req=%b v=%b cur=%h, want 0 0 fffffffc", w_req, w_valid, w_cur);
        end
        reset = 1;
        model_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] p;
        for (int i = 0; i < 4; i++) begin
            p = 32'(4 * i);
            cyc(1, 0, 0, 0);
            n_vec++;
            if ({ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o, current_pc_o, imem_req_o, imem_addr_o}
                !== {1'b1, mem(p), p, p + 32'd4, p + 32'd4, 1'b1, p + 32'd4}) begin
                n_err++;
                $display("FAIL seq[%0d]: got v=%b instr=%h pc=%h pc4=%h cur=%h req=%b addr=%h, want pc=%h",
                         i, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o, current_pc_o, imem_req_o, imem_addr_o, p);
            end
            if (i < 2) begin
                p = i == 0 ? 32'hFFFF_FFFC : 32'h0;
                n_vec++;
                if ({w_valid, w_pc, w_pc4, w_cur} !== {1'b1, p, p + 32'd4, p + 32'd4}) begin
                    n_err++;
                    $display("FAIL wrap_seq[%0d]: got v=%b pc=%h pc4=%h cur=%h, want pc=%h pc4=%h",
                             i, w_valid, w_pc, w_pc4, w_cur, p, p + 32'd4);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0);
            n_vec++;
            if ({ifid_valid_o, ifid_pc_o, imem_req_o, current_pc_o} !== {1'b1, 32'h0C, 1'b0, 32'h14}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h req=%b cur=%h, want 1 0000000c 0 00000014",
                         i, ifid_valid_o, ifid_pc_o, imem_req_o, current_pc_o);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0);
            n_vec++;
            if ({ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_req_o} !== {1'b1, 32'(16 + 4 * i), mem(32'(16 + 4 * i)), 1'b1}) begin
                n_err++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h instr=%h req=%b, want pc=%h",
                         i, ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_req_o, 32'(16 + 4 * i));
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] f;
        for (int k = 0; k < 2; k++) begin
            f = 32'(24 + 4 * k);
            for (int w = 0; w < 2; w++) begin
                cyc(0, 0, 0, 0);
                n_vec++;
                if ({ifid_valid_o, imem_req_o, imem_addr_o, current_pc_o} !== {2'b01, f, f}) begin
                    n_err++;
                    $display("FAIL wait[%0d.%0d]: got v=%b req=%b addr=%h cur=%h, want 0 1 %h %h",
                             k, w, ifid_valid_o, imem_req_o, imem_addr_o, current_pc_o, f, f);
                end
            end
            cyc(1, 0, 0, 0);
            n_vec++;
            if ({ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_addr_o} !== {1'b1, f, mem(f), f + 32'd4}) begin
                n_err++;
                $display("FAIL wait_done[%0d]: got v=%b pc=%h instr=%h addr=%h, want pc=%h",
                         k, ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_addr_o, f);
            end
        end
    endtask

    task automatic test_redirect_ready();
        cyc(1, 0, 1, 32'h0000_0103);
        n_vec++;
        if ({ifid_valid_o, imem_req_o, imem_addr_o, current_pc_o} !== {2'b01, 32'h100, 32'h100}) begin
            n_err++;
            $display("FAIL redir_rdy: got v=%b req=%b addr=%h cur=%h, want 0 1 00000100 00000100",
                     ifid_valid_o, imem_req_o, imem_addr_o, current_pc_o);
        end
        cyc(1, 0, 0, 0);
        n_vec++;
        if ({ifid_valid_o, ifid_pc_o, ifid_instr_o} !== {1'b1, 32'h100, mem(32'h100)}) begin
            n_err++;
            $display("FAIL redir_rdy_target: got v=%b pc=%h instr=%h, want 1 00000100 %h",
                     ifid_valid_o, ifid_pc_o, ifid_instr_o, mem(32'h100));
        end
        cyc(1, 0, 1, 32'h40);
    endtask

    task automatic test_redirect_wait();
        for (int i = 0; i < 3; i++) begin
            cyc(i == 2, 0, i == 0, 32'h200);
            n_vec++;
            if ({ifid_valid_o, imem_req_o, imem_addr_o, current_pc_o}
                !== {2'b01, i == 2 ? 32'h200 : 32'h40, 32'h200}) begin
                n_err++;
                $display("FAIL redir_wait[%0d]: got v=%b req=%b addr=%h cur=%h",
                         i, ifid_valid_o, imem_req_o, imem_addr_o, current_pc_o);
            end
        end
        cyc(1, 0, 0, 0);
        n_vec++;
        if ({ifid_valid_o, ifid_pc_o, ifid_instr_o, current_pc_o} !== {1'b1, 32'h200, mem(32'h200), 32'h204}) begin
            n_err++;
            $display("FAIL redir_wait_target: got v=%b pc=%h instr=%h cur=%h, want 1 00000200 %h 00000204",
                     ifid_valid_o, ifid_pc_o, ifid_instr_o, current_pc_o, mem(32'h200));
        end
    endtask

    task automatic test_wrap();
        cyc(1, 0, 1, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0);
        n_vec++;
        if ({ifid_valid_o, ifid_pc_o, ifid_pc4_o, current_pc_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC, 96'h0}) begin
            n_err++;
            $display("FAIL wrap: got v=%b pc=%h pc4=%h cur=%h addr=%h, want 1 fffffffc 0 0 0",
                     ifid_valid_o, ifid_pc_o, ifid_pc4_o, current_pc_o, imem_addr_o);
        end
    endtask

    task automatic test_random();
        logic        rdy, st, rd;
        logic [31:0] tgt;
        logic [193:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            rdy = $urandom_range(0, 3) != 0;
            st  = $urandom_range(0, 4) == 0;
            rd  = $urandom_range(0, 9) == 0;
            tgt = $urandom;
            cyc(rdy, st, rd, tgt);
            got = {imem_req_o, imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o, current_pc_o};
            exp = model_out();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random[%0d] rdy=%b st=%b rd=%b: got %h, want %h", i, rdy, st, rd, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (3) cyc(1, 0, 0, 0);
        n_vec++;
        if ({ifid_valid_o, imem_req_o} !== 2'b11) begin
            n_err++;
            $display("FAIL pre_reset: got v=%b req=%b, want 1 1", ifid_valid_o, imem_req_o);
        end
        #2 reset = 0;
        #1;
        n_vec++;
        if ({ifid_valid_o, imem_req_o, current_pc_o, ifid_pc_o, ifid_instr_o} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b req=%b cur=%h pc=%h instr=%h, want all zero",
                     ifid_valid_o, imem_req_o, current_pc_o, ifid_pc_o, ifid_instr_o);
        end
        n_vec++;
        if ({w_valid, w_req, w_cur} !== {2'b00, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL async_reset_wrap: got v=%b req=%b cur=%h, want 0 0 fffffffc", w_valid, w_req, w_cur);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_wait_states();
        test_redirect_ready();
        test_redirect_wait();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
